// File: rtl/spi_ram_pkg.sv
// Shared types and default widths for the SPI RAM master.
package spi_ram_pkg;

  localparam int unsigned DEF_CMD_WIDTH  = 10;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_END
  } state_t;

endpackage

// File: rtl/spi_ram_master_shifter.sv
// Parallel-load register walked MSB-first by a down-counter; each shift step
// overwrites the indexed bit with i_serial_in, so it serves as both PISO and SIPO.
module spi_ram_master_shifter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift_en,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_count <= CNT_W'(WIDTH - 1);
    end else if (i_shift_en) begin
      r_data[r_count] <= i_serial_in;
      if (r_count != '0) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_data  = r_data;
    o_count = r_count;
    o_done  = (r_count == '0);
  end

endmodule

// File: rtl/spi_ram_master.sv
// SPI initiator for the SPI-wrapped RAM: serialises command words, returns read bytes.
// Optional command-sequence checker enabled by SPI_RAM_MASTER_SEQ_CHECK_EN.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd_data,
  output logic                  cmd_ready,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  ,
  output logic                  seq_err
`endif
);

  localparam int unsigned TX_CNT_W = $clog2(CMD_WIDTH);
  localparam int unsigned RX_CNT_W = $clog2(DATA_WIDTH);

  state_t r_state;
  state_t w_next;

  logic                  r_is_read;
  logic [3:0]            r_wait_cnt;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic                  w_accept;
  opcode_t               w_cmd_op;
  logic                  w_tx_load;
  logic                  w_tx_shift;
  logic                  w_rx_load;
  logic                  w_rx_shift;
  logic                  w_wait_load;
  logic                  w_wait_dec;
  logic                  w_rsp_fire;

  logic [CMD_WIDTH-1:0]  w_tx_data;
  logic [TX_CNT_W-1:0]   w_tx_count;
  logic                  w_tx_done;
  logic [DATA_WIDTH-1:0] w_rx_data;
  logic [RX_CNT_W-1:0]   w_rx_count;
  logic                  w_rx_done;
  logic [DATA_WIDTH-1:0] w_rsp_next;

  always_comb begin
    cmd_ready = (r_state == ST_IDLE) && !rst_n;
    w_accept  = cmd_valid && cmd_ready;
    w_cmd_op  = opcode_t'(cmd_data[CMD_WIDTH-1 -: 2]);
  end

  spi_ram_master_shifter #(
    .WIDTH (CMD_WIDTH)
  ) u_tx (
    .clk         (clk),
    .i_rst       (rst_n),
    .i_load      (w_tx_load),
    .i_load_data (cmd_data),
    .i_shift_en  (w_tx_shift),
    .i_serial_in (1'b0),
    .o_data      (w_tx_data),
    .o_count     (w_tx_count),
    .o_done      (w_tx_done)
  );

  spi_ram_master_shifter #(
    .WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk         (clk),
    .i_rst       (rst_n),
    .i_load      (w_rx_load),
    .i_load_data ('0),
    .i_shift_en  (w_rx_shift),
    .i_serial_in (MISO),
    .o_data      (w_rx_data),
    .o_count     (w_rx_count),
    .o_done      (w_rx_done)
  );

  // The final MISO bit lands in the response register on the same edge it is sampled.
  always_comb begin
    w_rsp_next             = w_rx_data;
    w_rsp_next[w_rx_count] = MISO;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_rx_load   = 1'b0;
    w_rx_shift  = 1'b0;
    w_wait_load = 1'b0;
    w_wait_dec  = 1'b0;
    w_rsp_fire  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_tx_load = 1'b1;
          w_next    = ST_START;
        end
      end
      ST_START: begin
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_tx_shift = 1'b1;
        if (w_tx_done) begin
          if (r_is_read) begin
            w_wait_load = 1'b1;
            w_next      = ST_WAIT;
          end else begin
            w_next = ST_END;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_rx_load = 1'b1;
          w_next    = ST_RECV;
        end else begin
          w_wait_dec = 1'b1;
        end
      end
      ST_RECV: begin
        w_rx_shift = 1'b1;
        if (w_rx_done) begin
          w_rsp_fire = 1'b1;
          w_next     = ST_END;
        end
      end
      ST_END: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_is_read   <= 1'b0;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_data <= w_rsp_next;
      end
      if (w_accept) begin
        r_is_read <= (w_cmd_op == OP_RD_DATA);
      end
      if (w_wait_load) begin
        r_wait_cnt <= 4'(TURNAROUND - 1);
      end else if (w_wait_dec) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    SS_n      = !(r_state inside {ST_START, ST_SHIFT, ST_WAIT, ST_RECV});
    MOSI      = (r_state == ST_SHIFT) ? w_tx_data[w_tx_count] : 1'b0;
    busy      = (r_state != ST_IDLE);
    rsp_valid = r_rsp_valid;
    rsp_data  = r_rsp_data;
  end

`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  logic r_rd_addr_seen;
  logic r_wr_addr_seen;
  logic r_seq_err;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_rd_addr_seen <= 1'b0;
      r_wr_addr_seen <= 1'b0;
      r_seq_err      <= 1'b0;
    end else begin
      r_seq_err <= 1'b0;
      if (w_accept) begin
        unique case (w_cmd_op)
          OP_WR_ADDR: r_wr_addr_seen <= 1'b1;
          OP_WR_DATA: r_seq_err      <= !r_wr_addr_seen;
          OP_RD_ADDR: r_rd_addr_seen <= 1'b1;
          OP_RD_DATA: begin
            r_seq_err      <= !r_rd_addr_seen;
            r_rd_addr_seen <= 1'b0;
          end
          default: r_seq_err <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    seq_err = r_seq_err;
  end
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: directed frames plus a randomized tail,
// each compared cycle by cycle against a frame-level model of the protocol.
module tb_spi_ram_master;

  localparam int TA = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data  = '0;
  logic       MISO      = 1'b0;
  logic       cmd_ready;
  logic       SS_n;
  logic       MOSI;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       seq_obs;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_rsp = '0;
  bit         wr_seen  = 1'b0;
  bit         rd_seen  = 1'b0;

`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  logic seq_err;
  assign seq_obs = seq_err;
`else
  assign seq_obs = 1'b0;
`endif

  spi_ram_master #(
    .CMD_WIDTH  (10),
    .DATA_WIDTH (8),
    .TURNAROUND (TA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
    ,
    .seq_err   (seq_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // {SS_n, MOSI, rsp_valid, busy, cmd_ready, seq_err, rsp_data}
  function automatic logic [13:0] observed();
    return {SS_n, MOSI, rsp_valid, busy, cmd_ready, seq_obs, rsp_data};
  endfunction

  // Expected outputs at the j-th sampling point after the accepting edge.
  function automatic logic [13:0] expected(input logic [9:0] cmd, input int j,
                                           input logic [7:0] byte_in, input bit err);
    bit         rd   = (cmd[9:8] == 2'b11);
    int         len  = rd ? (1 + 10 + TA + 8) : 11;
    logic       mosi = (j >= 2 && j <= 11) ? cmd[11 - j] : 1'b0;
    logic [7:0] rsp  = (rd && j > len) ? byte_in : last_rsp;
    return {(j > len), mosi, (rd && j == len + 1), (j <= len + 1), (j == len + 2),
            (err && j == 1), rsp};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [9:0] cmd, output bit err);
    err = 1'b0;
    case (cmd[9:8])
      2'b00:   wr_seen = 1'b1;
      2'b01:   err = !wr_seen;
      2'b10:   rd_seen = 1'b1;
      default: begin
        err     = !rd_seen;
        rd_seen = 1'b0;
      end
    endcase
`ifndef SPI_RAM_MASTER_SEQ_CHECK_EN
    err = 1'b0;
`endif
  endtask

  // Sends one command and checks the whole frame. With hold set, cmd_valid stays
  // high carrying next_cmd throughout, so it must be taken only once IDLE returns.
  task automatic send(input logic [9:0] cmd, input logic [7:0] byte_in,
                      input bit hold, input logic [9:0] next_cmd);
    bit rd     = (cmd[9:8] == 2'b11);
    int len    = rd ? (1 + 10 + TA + 8) : 11;
    int waited = 0;
    bit err;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (cmd_ready === 1'b1)
    else begin
      errors++;
      $error("FAIL accept_wait cmd=%h observed_ready=%b expected_ready=1", cmd, cmd_ready);
    end
    model_accept(cmd, err);
    for (int j = 1; j <= len + 2; j++) begin
      @(negedge clk);
      check($sformatf("frame_%h_cyc%0d", cmd, j), observed(), expected(cmd, j, byte_in, err));
      if (rd && j >= 12 + TA && j <= len) MISO = byte_in[len - j];
      else MISO = 1'($urandom);
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_data  = next_cmd;
      end else if (j <= len + 1) begin
        cmd_valid = 1'($urandom);
        cmd_data  = 10'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    if (rd) last_rsp = byte_in;
  endtask

  initial begin
    bit         err;
    logic [9:0] cur;
    logic [9:0] nxt;
    logic [7:0] rb;
    bit         hold;

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_after_reset", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});

    send(10'b00_0011_0011, 8'h00, 1'b0, 10'h000);
    send(10'h300, 8'hC3, 1'b0, 10'h000);
    send(10'h25A, 8'h00, 1'b0, 10'h000);
    send(10'h3E7, 8'h5A, 1'b0, 10'h000);
    send(10'h005, 8'h00, 1'b1, 10'h1AA);
    send(10'h1AA, 8'h00, 1'b0, 10'h000);

    // Reset asserted while bit 4 of the command is on MOSI.
    cmd_valid = 1'b1;
    cmd_data  = 10'h0A5;
    check("abort_ready", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, last_rsp});
    model_accept(10'h0A5, err);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check($sformatf("abort_frame_cyc%0d", j), observed(), expected(10'h0A5, j, 8'h00, err));
      MISO = 1'($urandom);
    end
    rst_n = 1'b1;
    @(negedge clk);
    wr_seen  = 1'b0;
    rd_seen  = 1'b0;
    last_rsp = '0;
    check("abort_in_reset", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_idle_%0d", k), observed(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    end

    send(10'h155, 8'h00, 1'b0, 10'h000);

    nxt = 10'($urandom);
    for (int n = 0; n < 20; n++) begin
      cur  = nxt;
      nxt  = 10'($urandom);
      rb   = 8'($urandom);
      hold = 1'($urandom);
      send(cur, rb, hold, nxt);
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
